// File: rtl/fmul_seq.sv
// fmul_seq: sequential IEEE-754 multiplier for binary32 / binary16 operands
// with selectable rounding (RNE or truncate) and exception flags.
// The mantissa product is built by a shift-add loop that consumes STEP
// multiplier bits per cycle. One operation is in flight at a time.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE, rst=0)
//   op_a, op_b           operands (half mode uses bits [15:0])
//   mode_fp              1 = single, 0 = half
//   round_mode           0 = round-to-nearest-even, 1 = truncate
//   out_valid/out_ready  result handshake
//   re                   result (upper half zero in half mode)
//   flags                {invalid, overflow, underflow, inexact}
module fmul_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mode_fp,
  input  logic        round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] re,
  output logic [3:0]  flags
);
  localparam int N_SP = (24 + STEP - 1) / STEP;
  localparam int N_HP = (11 + STEP - 1) / STEP;
  localparam logic [4:0] CNT_SP = 5'(N_SP - 1);
  localparam logic [4:0] CNT_HP = 5'(N_HP - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t state;

  logic        sign_reg, mode_reg, rnd_reg;
  logic [7:0]  ea_reg, eb_reg;
  logic [23:0] mb_reg;
  logic [47:0] mcand_reg, acc_reg;
  logic [4:0]  cnt_reg;

  assign in_ready = (state == IDLE) && !rst;

  // Unpack both formats into a common layout: 8-bit exponent, 23-bit
  // fraction field (half fractions left-justified so the quiet bit is [22]).
  logic [7:0]  ea_in, eb_in, emax_in;
  logic [22:0] fa_in, fb_in;
  logic        sign_in;
  logic [23:0] ma_in, mb_in;
  always_comb begin
    if (mode_fp) begin
      ea_in   = op_a[30:23];
      eb_in   = op_b[30:23];
      fa_in   = op_a[22:0];
      fb_in   = op_b[22:0];
      emax_in = 8'hFF;
      sign_in = op_a[31] ^ op_b[31];
      ma_in   = {1'b1, fa_in};
      mb_in   = {1'b1, fb_in};
    end else begin
      ea_in   = {3'b000, op_a[14:10]};
      eb_in   = {3'b000, op_b[14:10]};
      fa_in   = {op_a[9:0], 13'd0};
      fb_in   = {op_b[9:0], 13'd0};
      emax_in = 8'h1F;
      sign_in = op_a[15] ^ op_b[15];
      ma_in   = {13'd0, 1'b1, op_a[9:0]};
      mb_in   = {13'd0, 1'b1, op_b[9:0]};
    end
  end

  // Denormal inputs are treated as zero.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  assign a_zero = (ea_in == 8'd0);
  assign b_zero = (eb_in == 8'd0);
  assign a_inf  = (ea_in == emax_in) && (fa_in == 23'd0);
  assign b_inf  = (eb_in == emax_in) && (fb_in == 23'd0);
  assign a_nan  = (ea_in == emax_in) && (fa_in != 23'd0);
  assign b_nan  = (eb_in == emax_in) && (fb_in != 23'd0);
  assign a_snan = a_nan && !fa_in[22];
  assign b_snan = b_nan && !fb_in[22];

  logic        spec_hit;
  logic [31:0] spec_re;
  logic [3:0]  spec_fl;
  always_comb begin
    spec_hit = 1'b1;
    spec_re  = '0;
    spec_fl  = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      spec_re = mode_fp ? 32'h7FC0_0000 : 32'h0000_7E00;
      spec_fl = {(a_zero && b_inf) || (a_inf && b_zero) || a_snan || b_snan, 3'b000};
    end else if (a_inf || b_inf) begin
      spec_re = mode_fp ? {sign_in, 8'hFF, 23'd0} : {16'd0, sign_in, 5'h1F, 10'd0};
    end else if (a_zero || b_zero) begin
      spec_re = mode_fp ? {sign_in, 31'd0} : {16'd0, sign_in, 15'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // STEP partial products per MUL cycle: multiplicand shifted by bit position
  // within the current multiplier chunk.
  logic [47:0] pp [STEP];
  for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
    assign pp[gi] = mb_reg[gi] ? (mcand_reg << gi) : 48'd0;
  end

  logic [47:0] pp_sum;
  always_comb begin
    pp_sum = acc_reg;
    for (int j = 0; j < STEP; j++) pp_sum = pp_sum + pp[j];
  end

  // Normalisation and rounding. Half products are first moved up so that
  // both formats share the same bit positions for the leading one.
  logic [47:0] aligned;
  logic [46:0] nm;
  logic        sh, g, r, s, lsb, inc, carry, ovf, unf;
  logic [23:0] sum_s;
  logic [10:0] sum_h;
  logic [9:0]  exp_n, exp_f;
  logic [31:0] norm_re;
  logic [3:0]  norm_fl;
  always_comb begin
    aligned = mode_reg ? acc_reg : (acc_reg << 26);
    sh      = aligned[47];
    nm      = sh ? aligned[46:0] : {aligned[45:0], 1'b0};
    if (mode_reg) begin
      g = nm[23]; r = nm[22]; s = |nm[21:0]; lsb = nm[24];
    end else begin
      g = nm[36]; r = nm[35]; s = |nm[34:0]; lsb = nm[37];
    end
    inc   = !rnd_reg && g && (r || s || lsb);
    sum_s = {1'b0, nm[46:24]} + {23'd0, inc};
    sum_h = {1'b0, nm[46:37]} + {10'd0, inc};
    carry = mode_reg ? sum_s[23] : sum_h[10];
    // 10-bit two's complement exponent; a rounding carry leaves a zero fraction.
    exp_n = {2'b00, ea_reg} + {2'b00, eb_reg} - (mode_reg ? 10'd127 : 10'd15) + {9'd0, sh};
    exp_f = exp_n + {9'd0, carry};
    ovf   = $signed(exp_f) >= (mode_reg ? 10'sd255 : 10'sd31);
    unf   = $signed(exp_f) <= 10'sd0;
    norm_fl = {1'b0, ovf, unf, g || r || s || ovf || unf};
    if (ovf) begin
      if (rnd_reg)
        norm_re = mode_reg ? {sign_reg, 8'hFE, 23'h7FFFFF} : {16'd0, sign_reg, 5'h1E, 10'h3FF};
      else
        norm_re = mode_reg ? {sign_reg, 8'hFF, 23'd0} : {16'd0, sign_reg, 5'h1F, 10'd0};
    end else if (unf) begin
      norm_re = mode_reg ? {sign_reg, 31'd0} : {16'd0, sign_reg, 15'd0};
    end else begin
      norm_re = mode_reg ? {sign_reg, exp_f[7:0], sum_s[22:0]}
                         : {16'd0, sign_reg, exp_f[4:0], sum_h[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      re        <= '0;
      flags     <= '0;
      sign_reg  <= 1'b0;
      mode_reg  <= 1'b0;
      rnd_reg   <= 1'b0;
      ea_reg    <= '0;
      eb_reg    <= '0;
      mb_reg    <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_reg  <= sign_in;
            mode_reg  <= mode_fp;
            rnd_reg   <= round_mode;
            ea_reg    <= ea_in;
            eb_reg    <= eb_in;
            mcand_reg <= {24'd0, ma_in};
            mb_reg    <= mb_in;
            acc_reg   <= '0;
            cnt_reg   <= mode_fp ? CNT_SP : CNT_HP;
            if (spec_hit) begin
              re        <= spec_re;
              flags     <= spec_fl;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc_reg   <= pp_sum;
          mcand_reg <= mcand_reg << STEP;
          mb_reg    <= mb_reg >> STEP;
          cnt_reg   <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd0) state <= NORM;
        end
        NORM: begin
          re        <= norm_re;
          flags     <= norm_fl;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmul_seq.sv
// Directed bench for fmul_seq: two instances (STEP=1 and STEP=4) share the
// input side so each vector checks both datapath widths and their latencies.
module tb_fmul_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, mode_fp, round_mode, out_ready;
  logic [31:0] op_a, op_b;
  logic        ir1, ir4, ov1, ov4;
  logic [31:0] re1, re4;
  logic [3:0]  fl1, fl4;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fmul_seq #(.STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .op_a(op_a), .op_b(op_b), .mode_fp(mode_fp), .round_mode(round_mode),
    .out_valid(ov1), .out_ready(out_ready), .re(re1), .flags(fl1)
  );

  fmul_seq #(.STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .op_a(op_a), .op_b(op_b), .mode_fp(mode_fp), .round_mode(round_mode),
    .out_valid(ov4), .out_ready(out_ready), .re(re4), .flags(fl4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one operation, wait (bounded) for both results, check them and
  // the latencies (edges after the acceptance edge), then complete the handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic rnd, input logic [31:0] exp_re,
                        input logic [3:0] exp_fl, input int exp_l1, input int exp_l4);
    int l1, l4, k;
    l1 = -1;
    l4 = -1;
    k  = 0;
    op_a = a; op_b = b; mode_fp = m; round_mode = rnd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; mode_fp = ~m; round_mode = ~rnd;
    while ((l1 < 0 || l4 < 0) && k <= 60) begin
      if (l1 < 0 && ov1) l1 = k;
      if (l4 < 0 && ov4) l4 = k;
      if (l1 < 0 || l4 < 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, " re s1"}, re1, exp_re);
    check({tag, " re s4"}, re4, exp_re);
    check({tag, " flags s1"}, {28'd0, fl1}, {28'd0, exp_fl});
    check({tag, " flags s4"}, {28'd0, fl4}, {28'd0, exp_fl});
    check({tag, " latency s1"}, l1, exp_l1);
    check({tag, " latency s4"}, l4, exp_l4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post-handshake {ir1,ir4,ov1,ov4}"}, {28'd0, ir1, ir4, ov1, ov4}, 32'hC);
    $display("[TB] %s: a=%h b=%h re=%h/%h flags=%b/%b lat=%0d/%0d", tag, a, b, re1, re4, fl1, fl4, l1, l4);
  endtask

  initial begin
    int k;
    logic seen_ov;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode_fp = 1'b1; round_mode = 1'b0; op_a = '0; op_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {30'd0, ir1, ir4}, 32'd0);
    check("reset out_valid", {30'd0, ov1, ov4}, 32'd0);
    check("reset re s1", re1, 32'd0);
    check("reset re s4", re4, 32'd0);
    check("reset flags", {24'd0, fl1, fl4}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", {30'd0, ir1, ir4}, 32'd3);

    // Normal path, rounding, overflow, underflow
    run_op("mul1x2_s",   32'h3F800000, 32'h40000000, 1'b1, 1'b0, 32'h40000000, 4'b0000, 25, 7);
    run_op("mul3x4_s",   32'h40400000, 32'h40800000, 1'b1, 1'b0, 32'h41400000, 4'b0000, 25, 7);
    run_op("mul3x4_h",   32'h00004200, 32'h00004400, 1'b0, 1'b0, 32'h00004A00, 4'b0000, 12, 4);
    run_op("ovf_rne_s",  32'h7F000000, 32'h40000000, 1'b1, 1'b0, 32'h7F800000, 4'b0101, 25, 7);
    run_op("ovf_trn_s",  32'h7F000000, 32'h40000000, 1'b1, 1'b1, 32'h7F7FFFFF, 4'b0101, 25, 7);
    run_op("inexact_s",  32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 1'b0, 32'h407FFFFE, 4'b0001, 25, 7);
    run_op("tie_rne_h",  32'h00003C01, 32'h00003E00, 1'b0, 1'b0, 32'h00003E02, 4'b0001, 12, 4);
    run_op("tie_trn_h",  32'h00003C01, 32'h00003E00, 1'b0, 1'b1, 32'h00003E01, 4'b0001, 12, 4);
    run_op("ovf_trn_h",  32'h00007BFF, 32'h00004000, 1'b0, 1'b1, 32'h00007BFF, 4'b0101, 12, 4);
    run_op("undf_s",     32'h00800000, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 4'b0011, 25, 7);
    // Special cases: out_valid already high right after the acceptance edge
    run_op("zero_inf_s", 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 0, 0);
    run_op("negzero_s",  32'h80000000, 32'h3F800000, 1'b1, 1'b0, 32'h80000000, 4'b0000, 0, 0);
    run_op("snan_s",     32'h7F800001, 32'h3F800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 0, 0);
    run_op("inf_neg_s",  32'h7F800000, 32'hC0000000, 1'b1, 1'b0, 32'hFF800000, 4'b0000, 0, 0);
    run_op("qnan_h",     32'h00007E00, 32'h00003C00, 1'b0, 1'b0, 32'h00007E00, 4'b0000, 0, 0);

    // Backpressure: hold result for 5 cycles with new operands offered
    op_a = 32'h40400000; op_b = 32'h40800000; mode_fp = 1'b1; round_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h3F800000; op_b = 32'h3F800000;
    k = 0;
    while (!(ov1 && ov4) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp both valid", {30'd0, ov1, ov4}, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp re s1", re1, 32'h41400000);
      check("bp re s4", re4, 32'h41400000);
      check("bp flags/in_ready", {24'd0, fl1, fl4}, 32'd0);
      check("bp in_ready", {30'd0, ir1, ir4}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release {ir1,ir4,ov1,ov4}", {28'd0, ir1, ir4, ov1, ov4}, 32'hC);
    $display("[TB] backpressure: held re=%h for 5 cycles", re1);

    // Reset during MUL aborts the operation
    op_a = 32'h3F800000; op_b = 32'h40000000; mode_fp = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-mul in_ready", {30'd0, ir1, ir4}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out_valid", {30'd0, ov1, ov4}, 32'd0);
    check("abort re s1", re1, 32'd0);
    check("abort re s4", re4, 32'd0);
    rst = 1'b0;
    #1;
    check("abort in_ready", {30'd0, ir1, ir4}, 32'd3);
    seen_ov = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ov1 || ov4) seen_ov = 1'b1;
    end
    check("abort no stale out_valid", {31'd0, seen_ov}, 32'd0);
    $display("[TB] reset mid-MUL: out_valid=%b%b re=%h", ov1, ov4, re1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
